// File: rtl/reg_file_pkg.sv
// Shared constants and dump FSM state encoding for the 32-entry register file.
package reg_file_pkg;

  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(REG_NUM - 1);

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_LOAD,
    DUMP_BEAT,
    DUMP_FIN
  } dump_state_e;

endpackage

// File: rtl/rf_dump_fsm.sv
// Streams every register out as a valid/ready beat sequence; each beat holds
// the value snapshotted in the LOAD cycle that precedes it.
module rf_dump_fsm
  import reg_file_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dump_req,
  input  logic                 dump_ready,
  output logic [REG_IDX_W-1:0] rd_idx,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 dump_valid,
  output logic [REG_IDX_W-1:0] dump_idx,
  output logic [DATA_W-1:0]    dump_data,
  output logic                 dump_busy,
  output logic                 dump_done
);

  dump_state_e          state_reg, state_next;
  logic [REG_IDX_W-1:0] idx_reg, idx_next;
  logic [DATA_W-1:0]    data_reg, data_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= DUMP_IDLE;
      idx_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    dump_valid = 1'b0;
    dump_busy  = 1'b1;
    dump_done  = 1'b0;
    unique case (state_reg)
      DUMP_IDLE: begin
        dump_busy = 1'b0;
        if (dump_req) begin
          state_next = DUMP_LOAD;
          idx_next   = '0;
        end
      end
      DUMP_LOAD: begin
        // rd_data already carries any same-cycle write to this index
        data_next  = rd_data;
        state_next = DUMP_BEAT;
      end
      DUMP_BEAT: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DUMP_FIN;
          end else begin
            idx_next   = idx_reg + REG_IDX_W'(1);
            state_next = DUMP_LOAD;
          end
        end
      end
      DUMP_FIN: begin
        dump_done  = 1'b1;
        state_next = DUMP_IDLE;
      end
      default: state_next = DUMP_IDLE;
    endcase
  end

  assign rd_idx    = idx_reg;
  assign dump_idx  = idx_reg;
  assign dump_data = data_reg;

endmodule

// File: rtl/reg_file.sv
// 32 x DATA_W register file: two combinational read ports with optional
// write forwarding, one write port, and a register dump streamer.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rf_we,
  input  logic [REG_IDX_W-1:0] wR,
  input  logic [DATA_W-1:0]    wd,
  input  logic [REG_IDX_W-1:0] rR1,
  input  logic [REG_IDX_W-1:0] rR2,
  output logic [DATA_W-1:0]    rD1,
  output logic [DATA_W-1:0]    rD2,
  input  logic                 dump_req,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [REG_IDX_W-1:0] dump_idx,
  output logic [DATA_W-1:0]    dump_data,
  output logic                 dump_busy,
  output logic                 dump_done
);

  localparam int RD_PORTS = 3;

  logic [DATA_W-1:0]    regs_reg [REG_NUM];
  logic [REG_IDX_W-1:0] rd_idx   [RD_PORTS];
  logic [DATA_W-1:0]    rd_data  [RD_PORTS];
  logic [REG_IDX_W-1:0] dump_rd_idx;
  logic                 fwd_en;

  // Entry 0 is cleared on reset and never written, so it stays zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (rf_we && (wR != '0)) begin
      regs_reg[wR] <= wd;
    end
  end

  // Forwarding is suppressed in reset so reads show the stored (cleared) state.
  assign fwd_en = (BYPASS != 0) && rst_n && rf_we && (wR != '0);

  assign rd_idx[0] = rR1;
  assign rd_idx[1] = rR2;
  assign rd_idx[2] = dump_rd_idx;

  for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_read
    assign rd_data[gi] = (rd_idx[gi] == '0)           ? '0 :
                         (fwd_en && (wR == rd_idx[gi])) ? wd :
                                                          regs_reg[rd_idx[gi]];
  end

  assign rD1 = rd_data[0];
  assign rD2 = rd_data[1];

  rf_dump_fsm #(
    .DATA_W(DATA_W)
  ) u_dump (
    .clk       (clk),
    .rst_n     (rst_n),
    .dump_req  (dump_req),
    .dump_ready(dump_ready),
    .rd_idx    (dump_rd_idx),
    .rd_data   (rd_data[2]),
    .dump_valid(dump_valid),
    .dump_idx  (dump_idx),
    .dump_data (dump_data),
    .dump_busy (dump_busy),
    .dump_done (dump_done)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, randomized reads and
// writes against an array model, and several dump scenarios.
module tb_reg_file;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, rf_we, dump_req, dump_ready;
  logic [4:0]   wR, rR1, rR2;
  logic [W-1:0] wd;
  logic [W-1:0] rD1, rD2, rD1_nb, rD2_nb;
  logic         dump_valid, dump_busy, dump_done;
  logic         dump_valid_nb, dump_busy_nb, dump_done_nb;
  logic [4:0]   dump_idx, dump_idx_nb;
  logic [W-1:0] dump_data, dump_data_nb;

  reg_file #(.DATA_W(W), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rf_we(rf_we), .wR(wR), .wd(wd),
    .rR1(rR1), .rR2(rR2), .rD1(rD1), .rD2(rD2),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy),
    .dump_done(dump_done)
  );

  reg_file #(.DATA_W(W), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rf_we(rf_we), .wR(wR), .wd(wd),
    .rR1(rR1), .rR2(rR2), .rD1(rD1_nb), .rD2(rD2_nb),
    .dump_req(dump_req), .dump_valid(dump_valid_nb), .dump_ready(dump_ready),
    .dump_idx(dump_idx_nb), .dump_data(dump_data_nb), .dump_busy(dump_busy_nb),
    .dump_done(dump_done_nb)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] model [32];

  typedef struct {
    logic       we;
    logic [4:0] wr;
    logic [W-1:0] wd;
    logic [4:0] r1;
    logic [4:0] r2;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    logic [W-1:0] n1;
    logic [W-1:0] n2;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Architectural read rule: x0 is zero, a live write forwards when enabled.
  function automatic logic [W-1:0] ref_read(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return '0;
    if (byp && rst_n && rf_we && (wR == idx)) return wd;
    return model[idx];
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      foreach (model[k]) model[k] = '0;
    end else if (rf_we && (wR != 5'd0)) begin
      model[wR] = wd;
    end
    #2;
  endtask

  task automatic check_reads(input string tag);
    #1;
    chk({tag, "_rD1"},    rD1,    ref_read(rR1, 1'b1));
    chk({tag, "_rD2"},    rD2,    ref_read(rR2, 1'b1));
    chk({tag, "_rD1_nb"}, rD1_nb, ref_read(rR1, 1'b0));
    chk({tag, "_rD2_nb"}, rD2_nb, ref_read(rR2, 1'b0));
  endtask

  // mode 0: ready held high; 1: stall at idx 3 with writes and extra request;
  // 2: random ready/writes; 3: reset while beat 10 is presented.
  task automatic run_dump(input int mode, input string tag);
    int   beats = 0;
    int   exp_idx = 0;
    int   done_cyc = -1;
    int   stall = 0;
    bit   seen_done = 0;
    bit   aborted = 0;
    bit   prev_valid = 0;
    logic [W-1:0] prev_view [32];
    logic [W-1:0] got [32];
    logic [W-1:0] beat_exp = '0;
    foreach (got[k]) got[k] = 'x;
    dump_req   = 1'b1;
    dump_ready = 1'b1;
    rf_we      = 1'b0;
    rR1        = 5'($urandom_range(31));
    rR2        = 5'($urandom_range(31));
    check_reads({tag, "_c0"});
    foreach (prev_view[k]) prev_view[k] = ref_read(5'(k), 1'b1);
    step();
    for (int c = 1; c <= 300 && !seen_done && !aborted; c++) begin
      dump_req   = 1'b0;
      rf_we      = 1'b0;
      dump_ready = 1'b1;
      rR1        = 5'($urandom_range(31));
      rR2        = 5'($urandom_range(31));
      case (mode)
        1: if (dump_valid && dump_idx == 5'd3 && stall < 3) begin
             dump_ready = 1'b0;
             if (stall == 0) begin rf_we = 1'b1; wR = 5'd3; wd = 32'hDEAD; end
             if (stall == 1) begin rf_we = 1'b1; wR = 5'd4; wd = 32'hBEEF; dump_req = 1'b1; end
             if (stall == 2) dump_req = 1'b1;
             stall++;
           end
        2: begin
             dump_ready = 1'($urandom_range(1));
             rf_we      = 1'($urandom_range(1));
             wR         = 5'($urandom_range(31));
             wd         = $urandom;
             dump_req   = ($urandom_range(3) == 0);
             if ($urandom_range(1) == 1) rR1 = wR;
           end
        3: if (dump_valid && dump_idx == 5'd10) begin
             rst_n   = 1'b0;
             rf_we   = 1'b1;
             wR      = 5'd12;
             wd      = $urandom;
             aborted = 1'b1;
           end
        default: ;
      endcase
      check_reads(tag);
      chk({tag, "_busy"}, 32'(dump_busy), 32'd1);
      if (dump_valid && !prev_valid) begin
        chk({tag, "_idx"}, 32'(dump_idx), 32'(exp_idx));
        beat_exp = prev_view[dump_idx];
      end
      if (dump_valid) chk($sformatf("%s_data_idx%0d", tag, dump_idx), dump_data, beat_exp);
      if (dump_valid && dump_ready) begin
        got[dump_idx] = dump_data;
        beats++;
        exp_idx++;
      end
      if (dump_done) begin
        seen_done = 1'b1;
        done_cyc  = c;
        chk({tag, "_beats"}, 32'(beats), 32'd32);
      end
      prev_valid = dump_valid;
      foreach (prev_view[k]) prev_view[k] = ref_read(5'(k), 1'b1);
      step();
    end
    dump_req = 1'b0;
    rf_we    = 1'b0;
    if (mode == 3) begin
      chk({tag, "_reached_idx10"}, 32'(aborted), 32'd1);
      #1;
      chk({tag, "_rst_valid"}, 32'(dump_valid), 32'd0);
      chk({tag, "_rst_busy"},  32'(dump_busy),  32'd0);
      chk({tag, "_rst_done"},  32'(dump_done),  32'd0);
      chk({tag, "_rst_idx"},   32'(dump_idx),   32'd0);
      chk({tag, "_rst_data"},  dump_data,       32'd0);
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 32; i++) begin
        rR1 = 5'(i);
        rR2 = 5'(31 - i);
        #1;
        chk($sformatf("%s_clr_r%0d", tag, i), rD1, 32'd0);
        chk($sformatf("%s_clr_r%0d", tag, 31 - i), rD2, 32'd0);
        chk({tag, "_no_done"}, 32'(dump_done), 32'd0);
        step();
      end
    end else begin
      chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
      #1;
      chk({tag, "_idle_busy"},  32'(dump_busy),  32'd0);
      chk({tag, "_idle_valid"}, 32'(dump_valid), 32'd0);
      step();
      if (mode == 0) begin
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'd65);
        for (int i = 0; i < 32; i++) chk($sformatf("%s_beat%0d", tag, i), got[i], 32'(i) * 32'h11);
      end
      if (mode == 1) begin
        chk({tag, "_beat3"}, got[3], 32'h33);
        chk({tag, "_beat4"}, got[4], 32'hBEEF);
      end
    end
    $display("dump %s: %0d beats, done at cycle %0d", tag, beats, done_cyc);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd0,  32'h12345678, 32'h0,        32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h12345678, 32'h0,        32'h12345678, 32'h0};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'h12345678, 32'h0,        32'h12345678};
    vecs[4] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[6] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 32'hCAFEF00D, 32'h0,        32'h0,        32'h0};
    vecs[7] = '{1'b1, 5'd7,  32'h11111111, 5'd7,  5'd31, 32'h11111111, 32'hCAFEF00D, 32'hA5A5A5A5, 32'hCAFEF00D};
    foreach (model[k]) model[k] = 'x;

    // Reset with a simultaneous write; forwarding must stay off while in reset.
    rst_n = 1'b0; rf_we = 1'b1; wR = 5'd9; wd = 32'hDEADBEEF;
    rR1 = 5'd9; rR2 = 5'd0; dump_req = 1'b0; dump_ready = 1'b0;
    step();
    step();
    #1;
    chk("rst_rD1",        rD1,              32'd0);
    chk("rst_rD1_nb",     rD1_nb,           32'd0);
    chk("rst_dump_valid", 32'(dump_valid),  32'd0);
    chk("rst_dump_busy",  32'(dump_busy),   32'd0);
    chk("rst_dump_done",  32'(dump_done),   32'd0);
    chk("rst_dump_idx",   32'(dump_idx),    32'd0);
    chk("rst_dump_data",  dump_data,        32'd0);
    rst_n = 1'b1; rf_we = 1'b0;
    #1;
    chk("rst_override_r9", rD1, 32'd0);
    step();

    foreach (vecs[i]) begin
      rf_we = vecs[i].we; wR = vecs[i].wr; wd = vecs[i].wd;
      rR1 = vecs[i].r1; rR2 = vecs[i].r2;
      #1;
      chk($sformatf("vec%0d_rD1", i),    rD1,    vecs[i].e1);
      chk($sformatf("vec%0d_rD2", i),    rD2,    vecs[i].e2);
      chk($sformatf("vec%0d_rD1_nb", i), rD1_nb, vecs[i].n1);
      chk($sformatf("vec%0d_rD2_nb", i), rD2_nb, vecs[i].n2);
      $display("vec %0d: we=%0d wR=%0d wd=%h rR1=%0d rD1=%h rR2=%0d rD2=%h",
               i, vecs[i].we, vecs[i].wr, vecs[i].wd, rR1, rD1, rR2, rD2);
      step();
    end

    for (int i = 0; i < 150; i++) begin
      rf_we = 1'($urandom_range(1));
      wR    = 5'($urandom_range(31));
      wd    = $urandom;
      rR1   = ($urandom_range(3) == 0) ? wR : 5'($urandom_range(31));
      rR2   = ($urandom_range(3) == 0) ? wR : 5'($urandom_range(31));
      check_reads("rand");
      $display("rand %0d: we=%0d wR=%0d wd=%h rR1=%0d rD1=%h rR2=%0d rD2=%h",
               i, rf_we, wR, wd, rR1, rD1, rR2, rD2);
      step();
    end

    for (int i = 1; i < 32; i++) begin
      rf_we = 1'b1; wR = 5'(i); wd = 32'(i) * 32'h11;
      rR1 = 5'(i); rR2 = 5'(i - 1);
      check_reads("preload");
      step();
    end
    rf_we = 1'b0;

    run_dump(0, "dump_full");
    run_dump(1, "dump_stall");
    run_dump(2, "dump_rand");
    run_dump(3, "dump_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, register and data width.
REQ-002 Parameter BYPASS, default 1; 1 enables write-to-read forwarding, 0 disables it.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 rf_we  in  1  write-back enable from the WB stage.
REQ-006 wR  in  5  write-back destination register index.
REQ-007 wd  in  DATA_W  write-back data (selected ALU/DRAM/PC+4/immediate value).
REQ-008 rR1, rR2  in  5 each  read port indices.
REQ-009 rD1, rD2  out  DATA_W each  read port data.
REQ-010 dump_req  in  1  one-cycle request to stream all 32 registers.
REQ-011 dump_valid  out  1  dump beat valid.
REQ-012 dump_ready  in  1  consumer accepts beat.
REQ-013 dump_idx  out  5  register index of current beat.
REQ-014 dump_data  out  DATA_W  register value of current beat.
REQ-015 dump_busy  out  1  high while the dump FSM is not IDLE.
REQ-016 dump_done  out  1  one-cycle pulse after last beat accepted.

Function
REQ-017 Storage: 32 x DATA_W registers; x0 reads 0 always; writes with wR==0 are discarded.
REQ-018 Write: when rf_we=1 and wR!=0, reg[wR] <= wd at the rising edge.
REQ-019 Read: rD1/rD2 are combinational, zero-latency functions of rR1/rR2 and the current state.
REQ-020 Bypass (BYPASS=1): if rf_we=1, wR!=0 and wR==rRn, rDn = wd in the same cycle; BYPASS=0: rDn = stored value.
REQ-021 Both read ports may address the same register, including the register being written; each port resolves independently.
REQ-022 Dump FSM states: IDLE, LOAD, BEAT, FIN.
REQ-023 IDLE: dump_req=1 -> LOAD, index counter <= 0; otherwise stay.
REQ-024 LOAD (1 cycle): dump_data register <= value of reg[idx], bypass applied per REQ-020 on a same-cycle write; -> BEAT.
REQ-025 BEAT: dump_valid=1; dump_idx and dump_data stay stable until dump_valid&dump_ready.
REQ-026 BEAT accept with idx<31: idx increments -> LOAD. Accept with idx==31 -> FIN.
REQ-027 FIN (1 cycle): dump_done=1 -> IDLE.
REQ-028 dump_req outside IDLE is ignored; no queuing.
REQ-029 Writes during a dump are permitted and never stall. A beat already in BEAT shows its LOAD-time snapshot. Later indices show post-write values.
REQ-030 Dump throughput: one beat per 2 cycles when dump_ready is held high; a full dump takes 65 cycles from dump_req to dump_done.
REQ-031 dump_busy=1 in LOAD, BEAT and FIN.

Reset
REQ-032 rst_n=0 at a rising edge clears all 32 registers to 0. The FSM goes to IDLE and idx to 0. The dump_data register clears to 0.
REQ-033 Reset value of every output: dump_valid=0, dump_busy=0, dump_done=0, dump_idx=0, dump_data=0.
REQ-034 While rst_n=0, rD1/rD2 reflect stored values, i.e. 0 after the first reset edge.
REQ-035 Reset overrides a simultaneous write.
REQ-036 Reset mid-dump aborts the dump with no dump_done pulse.

Structure
REQ-037 The shared package holds REG_NUM=32, the REG_IDX_W=5 constant and the dump FSM state enumeration.
REQ-038 One sub-module, rf_dump_fsm, holds the FSM, index counter and snapshot register. It reads storage through an index/data port.

Verification
REQ-039 Reset, write wR=5 wd=0x12345678, next cycle rR1=5 -> rD1=0x12345678; rR2=0 -> rD2=0.
REQ-040 rf_we=1, wR=0, wd=0xFFFFFFFF, then rR1=0 -> rD1=0.
REQ-041 Same-cycle write wR=7 wd=0xA5A5A5A5 with rR1=rR2=7: BYPASS=1 -> rD1=rD2=0xA5A5A5A5 in that cycle; BYPASS=0 -> old value 0.
REQ-042 Preload reg[i]=i*0x11, dump_req pulse, dump_ready=1 -> 32 beats with idx 0..31 and data i*0x11 (idx0=0); dump_done at cycle 65.
REQ-043 During the dump, hold dump_ready=0 at idx=3 and write reg[3]=0xDEAD, reg[4]=0xBEEF. Result: beat 3 stays 0x33, beat 4 shows 0xBEEF. A second dump_req while busy causes no extra beats.
REQ-044 rst_n=0 during beat idx=10 -> next cycle dump_valid=0, dump_busy=0, no dump_done, all registers read 0.
